fru_config_controller: RTL and testbench
========================================

Name: fru_config_controller

Overview:
- Byte-serial configuration controller for the filter reduce unit.
- Parses the shared configId/configData broadcast bus and maintains the per-chain firmware tables: filter op, filter address and reduce axis.
- Loads filter bin vectors into the unit's FUVRF through RAM write port b.
- Sits between the global config distributor and one filter reduce unit instance.

Parameters:
M, 8, bin operands per FUVRF entry
DATA_WIDTH, 32, bits per operand; M*DATA_WIDTH must be a multiple of 8
MAX_CHAINS, 4, number of chains (power of 2, ≤64)
PERSONAL_CONFIG_ID, 0, configId value addressed to this unit
FUVRF_SIZE, 4, FUVRF entries (power of 2, ≤64)
INITIAL_FIRMWARE_FILTER_OP / _FILTER_ADDR / _REDUCE_AXIS, all 0, reset contents of the tables (8 bits per chain)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
tracing  in  1  tracing active; configuration forbidden while high
config_valid  in  1  config byte present this cycle
configId  in  8  target unit id
configData  in  8  config byte
firmware_filter_op  out  8*MAX_CHAINS  packed table, chain c at [8c+7:8c]
firmware_filter_addr  out  8*MAX_CHAINS  packed table
firmware_reduce_axis  out  8*MAX_CHAINS  packed table
mem_address_b  out  clog2(FUVRF_SIZE)  FUVRF write address
mem_write_enable_b  out  1  FUVRF write strobe
mem_in_b  out  M*DATA_WIDTH  FUVRF write data
busy  out  1  high in any state other than IDLE
cfg_done  out  1  one-cycle pulse on successful command completion
cfg_error  out  1  sticky error flag

Behaviour:
- A byte is accepted only when config_valid=1, configId=PERSONAL_CONFIG_ID and tracing=0. All other bytes are ignored and the FSM holds state.
- Reset (async, any time, including mid-command):
  - Tables load INITIAL_* values.
  - FSM goes to IDLE; byte counter and shift buffer cleared.
  - mem_write_enable_b=0, mem_address_b=0, mem_in_b=0.
  - busy=0, cfg_done=0, cfg_error=0.
- Command byte, accepted in IDLE:
  - cmd[7:6]: 00 = SET_OP, 01 = SET_ADDR, 10 = SET_AXIS, 11 = LOAD_FUVRF.
  - cmd[5:0] = index: chain for 00–10, FUVRF address for 11.
  - The index is latched.
- States:
  - IDLE --cmd 00/01/10--> WAIT_VAL.
  - IDLE --cmd 11--> LOAD. Byte counter = 0, buffer cleared.
  - WAIT_VAL --accepted byte--> IDLE. Selected table[index] <= byte; the new value is visible on the output port the cycle after acceptance. cfg_done pulses in that same cycle.
  - LOAD --accepted byte--> buffer <= {buffer[M*DATA_WIDTH-9:0], byte} (first byte ends in MSBs); counter++.
  - LOAD, on byte number M*DATA_WIDTH/8 --> WRITE.
  - WRITE: exactly one cycle, no input sampled. mem_write_enable_b=1, mem_address_b=index[clog2(FUVRF_SIZE)-1:0], mem_in_b=buffer; cfg_done=1. Next state IDLE.
- Latency: last payload byte accepted at cycle t → wren_b high during cycle t+1 only.
- Out-of-range index (chain ≥ MAX_CHAINS or address ≥ FUVRF_SIZE):
  - Payload is still consumed.
  - No table update and no wren_b pulse.
  - cfg_error set; no cfg_done.
- Tracing rising while busy: FSM aborts to IDLE the next cycle, buffer is discarded, no write occurs, cfg_error set. Tables are never modified while tracing=1.
- Matching byte presented while tracing=1: ignored and sets cfg_error.
- cfg_error clears only on reset.
- Back-to-back commands: a command byte may be accepted in the cycle immediately after a WAIT_VAL completion. After a LOAD, the earliest next command is the cycle after WRITE.
- Table outputs are registered. mem_* outputs are registered and are 0 whenever wren_b=0, except mem_address_b, which holds its last value.

Test Plan:
(Bench params: M=8, DATA_WIDTH=32, MAX_CHAINS=4, FUVRF_SIZE=4, PERSONAL_CONFIG_ID=3.)
- SET_OP: bytes (id3) 0x02, 0x01 → firmware_filter_op[23:16]=0x01 one cycle after the second byte, cfg_done pulse, other chains unchanged.
- LOAD_FUVRF: id3 0xC1 followed by 32 bytes 0x00..0x1F → single wren_b pulse, address=1, mem_in_b=0x00010203…1E1F, cfg_done=1.
- Interleaved foreign traffic: id5 bytes between id3 LOAD bytes → ignored; the write occurs only after the 32nd id3 byte, data unchanged.
- Bad index: id3 0x05, 0x07 → no table change, cfg_error=1, busy returns to 0.
- Abort: tracing asserted after 10 LOAD payload bytes → IDLE next cycle, no wren_b, cfg_error=1. A following SET_AXIS 0x83, 0x02 after tracing drops → reduce_axis chain3=0x02.
- Reset mid-LOAD: reset pulse after 5 bytes → tables back to INITIAL_*, busy=0, cfg_error=0; a subsequent full LOAD succeeds.

Source files
------------

// File: rtl/fru_config_controller.sv
// fru_config_controller
//   Byte-serial configuration front end for one filter reduce unit. It
//   listens to the shared configId/configData bus, keeps the per-chain
//   firmware tables (filter op, filter address, reduce axis) and assembles
//   FUVRF bin vectors that it writes through RAM port b.
// Ports
//   clk, reset            clock, async active-high reset
//   tracing               unit is tracing; configuration is refused
//   config_valid/configId/configData   broadcast config byte
//   firmware_*            packed 8-bit-per-chain tables, chain c at [8c+7:8c]
//   mem_*_b               FUVRF write port b (data zero when not writing)
//   busy, cfg_done, cfg_error          status (done pulses, error sticky)
module fru_config_controller #(
  parameter int M                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int FUVRF_SIZE         = 4,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_FILTER_OP   = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_FILTER_ADDR = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_REDUCE_AXIS = '0,
  localparam int AW = (FUVRF_SIZE > 1) ? $clog2(FUVRF_SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tracing,
  input  logic                       config_valid,
  input  logic [7:0]                 configId,
  input  logic [7:0]                 configData,
  output logic [8*MAX_CHAINS-1:0]    firmware_filter_op,
  output logic [8*MAX_CHAINS-1:0]    firmware_filter_addr,
  output logic [8*MAX_CHAINS-1:0]    firmware_reduce_axis,
  output logic [AW-1:0]              mem_address_b,
  output logic                       mem_write_enable_b,
  output logic [M*DATA_WIDTH-1:0]    mem_in_b,
  output logic                       busy,
  output logic                       cfg_done,
  output logic                       cfg_error
);

  localparam int VW     = M * DATA_WIDTH;
  localparam int NBYTES = VW / 8;
  localparam int CNTW   = $clog2(NBYTES + 1);
  localparam int CW     = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int IW     = (CW > AW) ? CW : AW;

  typedef enum logic [1:0] {IDLE, WAIT_VAL, LOAD, WRITE} state_t;

  state_t                         state_q;
  logic [1:0]                     cmd_q;
  logic [IW-1:0]                  idx_q;
  logic                           bad_q;    // latched index was out of range
  logic [CNTW-1:0]                cnt_q;
  logic [VW-1:0]                  buf_q;
  logic [MAX_CHAINS-1:0][7:0]     op_q, faddr_q, axis_q;
  logic [AW-1:0]                  maddr_q;
  logic                           wren_q, done_q, err_q;
  logic [VW-1:0]                  min_q;

  logic match, accept, bad_tbl, bad_mem;
  logic [VW+7:0] shl;

  assign match   = config_valid && (configId == 8'(PERSONAL_CONFIG_ID));
  assign accept  = match && !tracing;
  assign bad_tbl = {1'b0, configData[5:0]} >= 7'(MAX_CHAINS);
  assign bad_mem = {1'b0, configData[5:0]} >= 7'(FUVRF_SIZE);
  // First payload byte ends up in the MSBs after NBYTES shifts.
  assign shl     = {buf_q, configData};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      buf_q   <= '0;
      op_q    <= INITIAL_FIRMWARE_FILTER_OP;
      faddr_q <= INITIAL_FIRMWARE_FILTER_ADDR;
      axis_q  <= INITIAL_FIRMWARE_REDUCE_AXIS;
      maddr_q <= '0;
      wren_q  <= 1'b0;
      min_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      min_q  <= '0;
      done_q <= 1'b0;
      if (match && tracing) err_q <= 1'b1;
      case (state_q)
        IDLE: if (accept) begin
          cmd_q <= configData[7:6];
          idx_q <= configData[IW-1:0];
          if (configData[7:6] == 2'b11) begin
            bad_q   <= bad_mem;
            cnt_q   <= '0;
            buf_q   <= '0;
            state_q <= LOAD;
          end else begin
            bad_q   <= bad_tbl;
            state_q <= WAIT_VAL;
          end
        end
        WAIT_VAL: begin
          if (tracing) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (accept) begin
            state_q <= IDLE;
            if (bad_q) err_q <= 1'b1;
            else begin
              done_q <= 1'b1;
              case (cmd_q)
                2'b00:   op_q[idx_q[CW-1:0]]    <= configData;
                2'b01:   faddr_q[idx_q[CW-1:0]] <= configData;
                default: axis_q[idx_q[CW-1:0]]  <= configData;
              endcase
            end
          end
        end
        LOAD: begin
          if (tracing) begin
            // Partial vector is dropped; nothing reaches the FUVRF.
            err_q   <= 1'b1;
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (accept) begin
            buf_q <= shl[VW-1:0];
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNTW'(NBYTES - 1)) begin
              state_q <= WRITE;
              // Write port is registered so it fires during the WRITE cycle.
              if (bad_q) err_q <= 1'b1;
              else begin
                wren_q  <= 1'b1;
                maddr_q <= idx_q[AW-1:0];
                min_q   <= shl[VW-1:0];
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          buf_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign firmware_filter_op   = op_q;
  assign firmware_filter_addr = faddr_q;
  assign firmware_reduce_axis = axis_q;
  assign mem_address_b        = maddr_q;
  assign mem_write_enable_b   = wren_q;
  assign mem_in_b             = min_q;
  assign busy                 = (state_q != IDLE);
  assign cfg_done             = done_q;
  assign cfg_error            = err_q;

endmodule

// File: tb/tb_fru_config_controller.sv
// Scoreboard bench for fru_config_controller. Stimulus pushes the expected
// completion event (write port + table snapshot) just before the byte that
// should trigger it; a negedge monitor pops on every cfg_done/wren_b.
module tb_fru_config_controller;
  logic         clk, reset, tracing, config_valid;
  logic [7:0]   configId, configData;
  logic [31:0]  fop, fad, fax;
  logic [1:0]   maddr;
  logic         wren, busy, done, err;
  logic [255:0] min;

  fru_config_controller #(
    .M(8), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(3), .FUVRF_SIZE(4)
  ) dut (
    .clk(clk), .reset(reset), .tracing(tracing), .config_valid(config_valid),
    .configId(configId), .configData(configData),
    .firmware_filter_op(fop), .firmware_filter_addr(fad), .firmware_reduce_axis(fax),
    .mem_address_b(maddr), .mem_write_enable_b(wren), .mem_in_b(min),
    .busy(busy), .cfg_done(done), .cfg_error(err)
  );

  typedef struct packed {
    logic         wren;
    logic [1:0]   addr;
    logic [255:0] data;
    logic [95:0]  tbl;   // {axis, addr, op}
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] e_op, e_ad, e_ax;
  logic [1:0]  e_maddr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] id, input logic [7:0] d);
    config_valid = 1'b1; configId = id; configData = d;
    @(posedge clk); #1;
    config_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic w, input logic [255:0] d);
    exp_t e;
    e.wren = w; e.addr = e_maddr; e.data = d; e.tbl = {e_ax, e_ad, e_op};
    q.push_back(e);
  endtask

  // Full LOAD: command, then 32 bytes base+i; optional foreign id5 bytes
  // interleaved; expectation pushed right before the final byte.
  task automatic load(input logic [7:0] cmd, input logic [7:0] base, input bit foreign,
                      input bit exp_wr, input logic [255:0] d);
    send(8'd3, cmd);
    for (int i = 0; i < 32; i++) begin
      if (i == 31 && exp_wr) push(1'b1, d);
      send(8'd3, base + 8'(i));
      if (foreign && (i % 4 == 3)) send(8'd5, 8'hEE);
    end
    idle(2);
  endtask

  // Monitor: every completion must have been predicted.
  always @(negedge clk) begin
    if (!reset && (done || wren)) begin
      exp_t e;
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_event: got wren=%0b done=%0b addr=%0d expected none", wren, done, maddr);
      end else begin
        e = q.pop_front();
        chk("ev_done", {255'd0, done}, 256'd1);
        chk("ev_wren", {255'd0, wren}, {255'd0, e.wren});
        chk("ev_addr", {254'd0, maddr}, {254'd0, e.addr});
        chk("ev_data", min, e.data);
        chk("ev_tables", {160'd0, fax, fad, fop}, {160'd0, e.tbl});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; tracing = 1'b0; config_valid = 1'b0; configId = 8'd0; configData = 8'd0;
    e_op = '0; e_ad = '0; e_ax = '0; e_maddr = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_err", {255'd0, err}, 256'd0);
    chk("rst_done", {255'd0, done}, 256'd0);
    chk("rst_wren", {255'd0, wren}, 256'd0);
    chk("rst_maddr", {254'd0, maddr}, 256'd0);
    chk("rst_min", min, 256'd0);
    chk("rst_tables", {160'd0, fax, fad, fop}, 256'd0);
    reset = 1'b0;
    idle(1);

    // SET_OP chain 2 = 0x01
    send(8'd3, 8'h02);
    chk("setop_busy", {255'd0, busy}, 256'd1);
    e_op = 32'h0001_0000;
    push(1'b0, 256'd0);
    send(8'd3, 8'h01);
    idle(2);
    chk("setop_idle", {255'd0, busy}, 256'd0);

    // LOAD_FUVRF address 1 with 0x00..0x1F
    e_maddr = 2'd1;
    load(8'hC1, 8'h00, 1'b0, 1'b1,
         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("load_idle", {255'd0, busy}, 256'd0);

    // Interleaved foreign traffic, LOAD address 2 with 0x20..0x3F
    e_maddr = 2'd2;
    load(8'hC2, 8'h20, 1'b1, 1'b1,
         256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
    chk("inter_maddr_hold", {254'd0, maddr}, 256'd2);

    // Abort mid-LOAD by tracing
    send(8'd3, 8'hC0);
    for (int i = 0; i < 10; i++) send(8'd3, 8'h80 + 8'(i));
    chk("abort_pre_err", {255'd0, err}, 256'd0);
    chk("abort_pre_busy", {255'd0, busy}, 256'd1);
    tracing = 1'b1;
    idle(1);
    chk("abort_busy", {255'd0, busy}, 256'd0);
    chk("abort_err", {255'd0, err}, 256'd1);
    idle(2);
    tracing = 1'b0;
    send(8'd3, 8'h83);
    e_ax = 32'h0200_0000;
    push(1'b0, 256'd0);
    send(8'd3, 8'h02);
    idle(2);

    // Bad chain index; payload must be swallowed
    send(8'd3, 8'h05);
    send(8'd3, 8'h07);
    idle(1);
    chk("bad_busy", {255'd0, busy}, 256'd0);
    chk("bad_tables", {160'd0, fax, fad, fop}, {160'd0, e_ax, e_ad, e_op});
    send(8'd3, 8'h41);
    e_ad = 32'h0000_5500;
    push(1'b0, 256'd0);
    send(8'd3, 8'h55);
    idle(2);

    // Async reset mid-LOAD
    send(8'd3, 8'hC0);
    for (int i = 0; i < 5; i++) send(8'd3, 8'h90 + 8'(i));
    reset = 1'b1;
    #2;
    chk("mid_rst_busy", {255'd0, busy}, 256'd0);
    chk("mid_rst_err", {255'd0, err}, 256'd0);
    chk("mid_rst_tables", {160'd0, fax, fad, fop}, 256'd0);
    chk("mid_rst_maddr", {254'd0, maddr}, 256'd0);
    idle(1);
    reset = 1'b0;
    e_op = '0; e_ad = '0; e_ax = '0;
    idle(1);
    e_maddr = 2'd3;
    load(8'hC3, 8'h40, 1'b0, 1'b1,
         256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f);
    chk("post_rst_err", {255'd0, err}, 256'd0);

    // Matching byte during tracing: ignored, flags error
    tracing = 1'b1;
    send(8'd3, 8'h00);
    tracing = 1'b0;
    idle(1);
    chk("trace_byte_err", {255'd0, err}, 256'd1);
    chk("trace_byte_busy", {255'd0, busy}, 256'd0);

    // Out-of-range FUVRF address: payload consumed, no write
    reset = 1'b1; idle(1); reset = 1'b0; idle(1);
    e_maddr = 2'd0;
    load(8'hC4, 8'hF0, 1'b0, 1'b0, 256'd0);
    chk("badmem_err", {255'd0, err}, 256'd1);
    chk("badmem_busy", {255'd0, busy}, 256'd0);
    chk("badmem_maddr", {254'd0, maddr}, 256'd0);

    idle(3);
    chk("queue_empty", 256'(q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
